pipe_compare: RTL

- Parametrised, fully pipelined magnitude/equality comparator; next generation of the pipelined equality comparator.
- Adds ordered compares (LT/GE), a signed mode, configurable leaf group size and tree fan-in, valid tracking and a global stall.
- Used in datapaths needing wide compares at high Fmax.
- Throughput: one compare per enabled cycle.

---
 rtl/pipe_compare.sv | 138 +++++++++++++
 1 files changed

// File: rtl/pipe_compare.sv
// rtl/pipe_compare.sv - Pipelined magnitude/equality comparator with signed mode, valid tracking and stall
module pipe_compare #(
    parameter int WIDTH = 10,
    parameter int GROUP = 3,
    parameter int FANIN = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic             out
);

    function automatic int calc_levels(input int leaves, input int fanin);
        int n;
        int lv;
        n  = leaves;
        lv = 0;
        while (n > 1) begin
            n  = (n + fanin - 1) / fanin;
            lv = lv + 1;
        end
        return lv;
    endfunction

    localparam int LEAVES = (WIDTH + GROUP - 1) / GROUP;
    localparam int LEVELS = calc_levels(LEAVES, FANIN);
    localparam int PW     = LEAVES * GROUP;

    // Every level keeps LEAVES slots; slots past the real node count carry
    // the identity (eq=1, gt=0), so the last level can be reduced with &/|.
    logic [LEAVES-1:0] eq_d [0:LEVELS];
    logic [LEAVES-1:0] gt_d [0:LEVELS];
    logic [LEAVES-1:0] eq_q [0:LEVELS];
    logic [LEAVES-1:0] gt_q [0:LEVELS];
    logic [1:0]        op_q [0:LEVELS];
    logic [LEVELS:0]   vld_q;

    logic [WIDTH-1:0] a_adj;
    logic [WIDTH-1:0] b_adj;
    logic [PW-1:0]    pa;
    logic [PW-1:0]    pb;
    logic             eq_fin;
    logic             gt_fin;
    logic             res;

    always_comb begin
        logic e_acc;
        logic g_acc;
        int   idx;
        e_acc = 1'b1;
        g_acc = 1'b0;
        idx   = 0;
        for (int l = 0; l <= LEVELS; l++) begin
            eq_d[l] = '1;
            gt_d[l] = '0;
        end

        // Flipping the sign bit maps two's complement order onto unsigned order.
        a_adj = a;
        b_adj = b;
        if (op[2]) begin
            a_adj[WIDTH-1] = ~a[WIDTH-1];
            b_adj[WIDTH-1] = ~b[WIDTH-1];
        end
        pa = PW'(a_adj);
        pb = PW'(b_adj);

        for (int k = 0; k < LEAVES; k++) begin
            eq_d[0][k] = (pa[k*GROUP +: GROUP] == pb[k*GROUP +: GROUP]);
            gt_d[0][k] = (pa[k*GROUP +: GROUP] >  pb[k*GROUP +: GROUP]);
        end

        // Children are visited most significant first so gt is decided by the
        // highest differing child.
        for (int l = 1; l <= LEVELS; l++) begin
            for (int j = 0; j < LEAVES; j++) begin
                e_acc = 1'b1;
                g_acc = 1'b0;
                for (int c = FANIN - 1; c >= 0; c--) begin
                    idx = j * FANIN + c;
                    if (idx < LEAVES) begin
                        g_acc = g_acc | (e_acc & gt_q[l-1][idx]);
                        e_acc = e_acc & eq_q[l-1][idx];
                    end
                end
                eq_d[l][j] = e_acc;
                gt_d[l][j] = g_acc;
            end
        end
    end

    assign eq_fin = &eq_q[LEVELS];
    assign gt_fin = |gt_q[LEVELS];

    always_comb begin
        res = 1'b0;
        case (op_q[LEVELS])
            2'b00:   res = eq_fin;
            2'b01:   res = ~eq_fin;
            2'b10:   res = ~eq_fin & ~gt_fin;
            default: res = gt_fin | eq_fin;
        endcase
    end

    always_ff @(posedge clk) begin
        if (en) begin
            op_q[0] <= op[1:0];
            for (int l = 0; l <= LEVELS; l++) begin
                eq_q[l] <= eq_d[l];
                gt_q[l] <= gt_d[l];
            end
            for (int l = 1; l <= LEVELS; l++) begin
                op_q[l] <= op_q[l-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q     <= '0;
            out_valid <= 1'b0;
            out       <= 1'b0;
        end else if (en) begin
            vld_q[0] <= in_valid;
            for (int l = 1; l <= LEVELS; l++) begin
                vld_q[l] <= vld_q[l-1];
            end
            out_valid <= vld_q[LEVELS];
            out       <= res;
        end
    end

endmodule
